// File: rtl/alu_issue_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_packer_if
// Description : Beat-input / bundle-output handshake bundle for alu_issue_packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_packer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_oprand;
  logic [2:0] in_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] opcodes;
  logic [31:0] oprands;
  logic [7:0] bundle_cnt;
  logic       drop;

  modport master (
    output in_valid, in_oprand, in_opcode, out_ready,
    input  in_ready, out_valid, opcodes, oprands, bundle_cnt, drop
  );

  modport slave (
    input  in_valid, in_oprand, in_opcode, out_ready,
    output in_ready, out_valid, opcodes, oprands, bundle_cnt, drop
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_packer.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_packer
// Description : Packs four operand/opcode beats into one ALU issue bundle.
//               Optional partial-bundle timeout: define ALU_ISSUE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_packer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_packer_if.slave bus
);

  localparam logic [1:0] c_last_beat = 2'd3;

  logic [1:0]  r_beat;
  logic [23:0] r_fill_oprands;
  logic [5:0]  r_fill_opcodes;
  logic        r_out_valid;
  logic [8:0]  r_opcodes;
  logic [31:0] r_oprands;
  logic [7:0]  r_bundle_cnt;

  logic w_in_ready;
  logic w_accept;
  logic w_last_accept;
  logic w_consume;
  logic w_expire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_issue_packer: TIMEOUT_CYCLES must lie in 1..255");
  end

  // Only beat 3 can stall; earlier beats go to the fill register.
  assign w_in_ready    = (r_beat != c_last_beat) || !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_last_accept = w_accept && (r_beat == c_last_beat);
  assign w_consume     = r_out_valid && bus.out_ready;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] c_idle_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_idle;
  logic       r_drop;

  // Expiry is the last idle cycle; an arriving beat wins over the timeout.
  assign w_expire = (r_beat != 2'd0) && !w_accept && (r_idle == c_idle_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= 8'd0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_expire;
      if (w_accept || (r_beat == 2'd0) || w_expire) begin
        r_idle <= 8'd0;
      end else begin
        r_idle <= r_idle + 8'd1;
      end
    end
  end

  assign bus.drop = r_drop;
`else
  assign w_expire = 1'b0;
  assign bus.drop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat         <= 2'd0;
      r_fill_oprands <= 24'd0;
      r_fill_opcodes <= 6'd0;
    end else if (w_accept) begin
      r_beat <= r_beat + 2'd1;
      case (r_beat)
        2'd0: r_fill_oprands[23:16] <= bus.in_oprand;
        2'd1: begin
          r_fill_oprands[15:8] <= bus.in_oprand;
          r_fill_opcodes[5:3]  <= bus.in_opcode;
        end
        2'd2: begin
          r_fill_oprands[7:0]  <= bus.in_oprand;
          r_fill_opcodes[2:0]  <= bus.in_opcode;
        end
        default: ;
      endcase
    end else if (w_expire) begin
      r_beat         <= 2'd0;
      r_fill_oprands <= 24'd0;
      r_fill_opcodes <= 6'd0;
    end
  end

  // Output register only changes on a completed bundle, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_opcodes    <= 9'd0;
      r_oprands    <= 32'd0;
      r_bundle_cnt <= 8'd0;
    end else begin
      if (w_last_accept) begin
        r_out_valid <= 1'b1;
        r_opcodes   <= {r_fill_opcodes, bus.in_opcode};
        r_oprands   <= {r_fill_oprands, bus.in_oprand};
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      if (w_consume) begin
        r_bundle_cnt <= r_bundle_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.opcodes    = r_opcodes;
  assign bus.oprands    = r_oprands;
  assign bus.bundle_cnt = r_bundle_cnt;

endmodule
`default_nettype wire

// File: doc/alu_issue_packer.md
ALU_ISSUE_PACKER -- requirements
Module: alu_issue_packer

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, idle cycles before a partial bundle is discarded (range 1..255).
REQ-002 SHALL have: CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: IN_VALID  input  1  upstream beat valid.
REQ-005 SHALL have: IN_READY  output  1  beat accepted when IN_VALID && IN_READY at CLK edge.
REQ-006 SHALL have: IN_OPRAND  input  8  operand of current beat.
REQ-007 SHALL have: IN_OPCODE  input  3  opcode of current beat (ignored on beat 0).
REQ-008 SHALL have: OUT_VALID  output  1  bundle on OPCODES/OPRANDS valid for the ALU.
REQ-009 SHALL have: OUT_READY  input  1  ALU consumes bundle when OUT_VALID && OUT_READY.
REQ-010 SHALL have: OPCODES  output  9  packed opcodes, feeds ALU OPCODES.
REQ-011 SHALL have: OPRANDS  output  32  packed operands, feeds ALU OPRANDS.
REQ-012 SHALL have: BUNDLE_CNT  output  8  count of bundles consumed downstream.
REQ-013 SHALL have: DROP  output  1  one-cycle pulse when a partial bundle is discarded.

Function
REQ-014 SHALL collect one bundle as 4 accepted beats, tracked by a beat counter 0..3.
REQ-015 SHALL place beat k operand in OPRANDS[31-8k:24-8k] (beat 0 in MSB byte).
REQ-016 SHALL place beat k opcode (k=1..3) in OPCODES[11-3k:9-3k] (beat 1 in [8:6]).
REQ-017 SHALL accumulate beats 0..2 in an internal fill register, never disturbing the output register.
REQ-018 SHALL drive IN_READY = (beat != 3) || !OUT_VALID || OUT_READY, combinationally.
REQ-019 SHALL, on acceptance of beat 3, load the output register with fill data plus beat 3 and set OUT_VALID the next cycle (latency 1 cycle from last beat).
REQ-020 SHALL hold OPCODES, OPRANDS, OUT_VALID stable while OUT_VALID && !OUT_READY.
REQ-021 SHALL clear OUT_VALID after a consuming edge unless beat 3 is accepted in the same cycle, in which case the new bundle replaces it with OUT_VALID staying 1 (no bubble).
REQ-022 SHALL allow beats 0..2 of the next bundle to be accepted while the previous bundle waits in the output register.
REQ-023 SHALL wrap the beat counter 3 -> 0 after beat 3 acceptance.
REQ-024 SHALL increment BUNDLE_CNT by 1 on each consuming edge, wrapping 255 -> 0.
REQ-025 SHALL keep OPCODES/OPRANDS at last value after OUT_VALID falls.

Reset
REQ-026 SHALL, while RST=1, asynchronously force OUT_VALID=0, OPCODES=0, OPRANDS=0, BUNDLE_CNT=0, DROP=0, beat counter=0, fill register=0, idle counter=0.
REQ-027 SHALL discard any partial or pending bundle on reset mid-operation; IN_READY=1 immediately after reset release.

Configuration
REQ-028 SHALL, with ALU_ISSUE_TIMEOUT_EN defined, run an idle counter that increments each cycle the beat counter is nonzero and no beat is accepted, and clears on any acceptance or when beat counter is 0.
REQ-029 SHALL, with ALU_ISSUE_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT_CYCLES, reset beat counter and fill register to 0, pulse DROP for one cycle, leave output register and OUT_VALID untouched.
REQ-030 SHALL give acceptance priority over timeout if a beat arrives in the expiring cycle.
REQ-031 SHALL, without ALU_ISSUE_TIMEOUT_EN, omit the idle counter, never discard partial bundles, and tie DROP to 0.

Verification
REQ-032 SHALL cover: 4 beats back-to-back, operands 0x0C,0x06,0x02,0x04, opcodes x,000,010,100, OUT_READY=1 -> one cycle after beat 3, OUT_VALID=1, OPCODES=9'b000_010_100, OPRANDS=32'h0C060204, BUNDLE_CNT=1 after consume.
REQ-033 SHALL cover: OUT_READY=0, two bundles sent -> second bundle's beats 0..2 accepted, IN_READY=0 on beat 3, first bundle held stable; OUT_READY=1 -> second bundle appears next cycle with no OUT_VALID gap.
REQ-034 SHALL cover: 256 bundles consumed -> BUNDLE_CNT wraps to 0.
REQ-035 SHALL cover: RST pulsed after beat 2 with a pending output -> all outputs 0 asynchronously, next 4 beats form a fresh bundle.
REQ-036 SHALL cover (ALU_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=15): 2 beats then 15 idle cycles -> DROP=1 for one cycle, next beat lands in OPRANDS[31:24]; beat on 15th idle cycle -> no DROP.
REQ-037 SHALL cover (macro undefined): 2 beats, 100 idle cycles, 2 beats -> DROP never 1, bundle completes with all 4 operands.
